// File: rtl/servo_pkg.sv
// Shared types and constants for the five-channel servo ramp scheduler.
package servo_pkg;

  localparam int unsigned N_CH      = 5;
  localparam int unsigned W_US      = 16;
  localparam int unsigned MIN_US    = 1000;
  localparam int unsigned MAX_US    = 2000;
  localparam int unsigned CENTER_US = 1500;

  typedef logic [W_US-1:0] width_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  // Limit a commanded pulse width to the mechanically safe servo range.
  function automatic width_t clamp_us(input width_t w);
    if (w < width_t'(MIN_US)) begin
      return width_t'(MIN_US);
    end else if (w > width_t'(MAX_US)) begin
      return width_t'(MAX_US);
    end
    return w;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; frame_tick is high while the count sits on its last value.
module servo_frame_timer #(
  parameter int unsigned FRAME_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);

  localparam int unsigned CNT_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is derived from the next count so it is a flop aligned with the counter.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= (LAST == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/servo_ramp_scheduler.sv
// Accepts five servo target widths and slews each channel toward its target by at most
// STEP_US per servo frame, pulsing done once every channel has arrived.
module servo_ramp_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned FRAME_US = 20000,
  parameter int unsigned STEP_US  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [N_CH*W_US-1:0] cmd_targets,
  output logic [N_CH*W_US-1:0] width_out,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_tick
);

  localparam int unsigned FRAME_CYC = (CLK_HZ / 1000000) * FRAME_US;
  localparam logic signed [W_US:0] STEP_S = (W_US+1)'(STEP_US);

  state_e          state_q, state_d;
  width_t          cur_q [N_CH];
  width_t          cur_d [N_CH];
  width_t          tgt_q [N_CH];
  width_t          tgt_d [N_CH];
  width_t          slew  [N_CH];
  logic [N_CH-1:0] at_tgt;
  logic            done_q, done_d;

  servo_frame_timer #(
    .FRAME_CYC (FRAME_CYC)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick)
  );

  // Per-channel slew: a 17-bit signed difference keeps the direction unambiguous.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic signed [W_US:0] diff;
    width_t               nxt;

    assign diff = $signed({1'b0, tgt_q[ch]}) - $signed({1'b0, cur_q[ch]});

    always_comb begin
      if (diff > STEP_S) begin
        nxt = cur_q[ch] + width_t'(STEP_US);
      end else if (diff < -STEP_S) begin
        nxt = cur_q[ch] - width_t'(STEP_US);
      end else begin
        nxt = tgt_q[ch];
      end
    end

    assign slew[ch]                  = nxt;
    assign at_tgt[ch]                = (nxt == tgt_q[ch]);
    assign width_out[W_US*ch +: W_US] = cur_q[ch];
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          for (int i = 0; i < N_CH; i++) begin
            tgt_d[i] = clamp_us(cmd_targets[W_US*i +: W_US]);
          end
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (frame_tick) begin
          cur_d = slew;
          if (&at_tgt) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cur_q[i] <= width_t'(CENTER_US);
        tgt_q[i] <= width_t'(CENTER_US);
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RAMP);
  assign done      = done_q;

endmodule
